// File: rtl/ps2_key_pkg.sv
// -----------------------------------------------------------------------------
// ps2_key_pkg
// Shared constants for the PS/2 key-state tracker:
//   - scancodes of the default tracked keys (left, right, up, down, space)
//   - {brk, vld} tag values that mark make and break words on Data[9:8]
//   - the default packed KEY_CODES vector (index 0 in the LSBs)
//   - a small helper that tests a decoded word against one scancode
// -----------------------------------------------------------------------------
package ps2_key_pkg;

    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    localparam logic [1:0] TAG_MAKE  = 2'b01;
    localparam logic [1:0] TAG_BREAK = 2'b11;

    localparam logic [39:0] DEFAULT_KEY_CODES =
        {KEY_SPACE, KEY_DOWN, KEY_UP, KEY_RIGHT, KEY_LEFT};

    // True when the word carries a valid event for the given scancode.
    function automatic logic code_match(input logic [9:0] data, input logic [7:0] code);
        return data[8] && (data[7:0] == code);
    endfunction

endpackage

// File: rtl/ps2_key_channel.sv
// -----------------------------------------------------------------------------
// ps2_key_channel
// State of one tracked key: held level, press/release pulses, saturating hold
// counter with long-hold flag and, when PS2_KEY_REPEAT_EN is defined, a
// typematic repeat counter. Without the macro o_repeat is tied low.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_data[9:0]      {brk, vld, scancode}
//   o_held           key is down
//   o_press          one cycle on held 0->1
//   o_release        one cycle on held 1->0
//   o_long_hold      key held for at least HOLD_CYCLES edges
//   o_repeat         typematic pulse (0 without PS2_KEY_REPEAT_EN)
// -----------------------------------------------------------------------------
module ps2_key_channel #(
    parameter logic [7:0] KEY_CODE      = 8'h6B,
    parameter int         HOLD_CYCLES   = 25_000_000,
    parameter int         REPEAT_CYCLES = 5_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_data,
    output logic       o_held,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long_hold,
    output logic       o_repeat
);
    import ps2_key_pkg::*;

    localparam int            HW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("ps2_key_channel: HOLD_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("ps2_key_channel: REPEAT_CYCLES must be >= 1");
    end

    logic          r_held;
    logic          r_press;
    logic          r_release;
    logic          r_long_hold;
    logic [HW-1:0] r_hold_cnt;

    logic          w_make;
    logic          w_break;
    logic          w_held_nxt;
    logic          w_stay;
    logic [HW-1:0] w_hold_cnt_nxt;
    logic          w_long_nxt;

    // Decode the word and compute next held level and hold-counter value.
    always_comb begin
        w_make         = 1'b0;
        w_break        = 1'b0;
        w_held_nxt     = r_held;
        w_stay         = 1'b0;
        w_hold_cnt_nxt = '0;
        w_long_nxt     = 1'b0;

        if (code_match(i_data, KEY_CODE)) begin
            w_make  = (i_data[9:8] == TAG_MAKE);
            w_break = (i_data[9:8] == TAG_BREAK);
        end else begin
            w_make  = 1'b0;
            w_break = 1'b0;
        end

        if (w_make) begin
            w_held_nxt = 1'b1;
        end else if (w_break) begin
            w_held_nxt = 1'b0;
        end else begin
            w_held_nxt = r_held;
        end

        // The counter only runs on edges where the key was already down and
        // stays down, so it reads j exactly j edges after held rose.
        w_stay = r_held & w_held_nxt;
        if (!w_stay) begin
            w_hold_cnt_nxt = '0;
        end else if (r_hold_cnt == HOLD_MAX) begin
            w_hold_cnt_nxt = r_hold_cnt;
        end else begin
            w_hold_cnt_nxt = r_hold_cnt + HW'(1);
        end

        w_long_nxt = (w_hold_cnt_nxt == HOLD_MAX);
    end

    // Held level, edge pulses, hold counter and long-hold flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_held      <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long_hold <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_held      <= w_held_nxt;
            r_press     <= w_make & ~r_held;
            r_release   <= w_break & r_held;
            r_long_hold <= w_long_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
        end
    end

`ifdef PS2_KEY_REPEAT_EN
    localparam int            RW       = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic          r_repeat;
    logic [RW-1:0] r_rpt_cnt;

    // Typematic pulses: one on the long-hold rising edge, then every
    // REPEAT_CYCLES edges; the counter is idle until long-hold is reached.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_repeat  <= 1'b0;
            r_rpt_cnt <= '0;
        end else if (!w_long_nxt) begin
            r_repeat  <= 1'b0;
            r_rpt_cnt <= '0;
        end else if (!r_long_hold) begin
            r_repeat  <= 1'b1;
            r_rpt_cnt <= '0;
        end else if (r_rpt_cnt == RPT_LAST) begin
            r_repeat  <= 1'b1;
            r_rpt_cnt <= '0;
        end else begin
            r_repeat  <= 1'b0;
            r_rpt_cnt <= r_rpt_cnt + RW'(1);
        end
    end

    assign o_repeat = r_repeat;
`else
    assign o_repeat = 1'b0;
`endif

    assign o_held      = r_held;
    assign o_press     = r_press;
    assign o_release   = r_release;
    assign o_long_hold = r_long_hold;

endmodule

// File: rtl/ps2_key_tracker.sv
// -----------------------------------------------------------------------------
// ps2_key_tracker
// Tracks up to NUM_KEYS PS/2 scancodes from the decoded receiver word and
// reports per-key held level, press/release pulses, long-hold flag and
// (optionally) typematic repeat pulses, plus any-held and a key combo.
// Optional feature macro: PS2_KEY_REPEAT_EN (enables repeat_pulse; without it
// repeat_pulse is constant 0).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   Data[9:0]                 {brk, vld, scancode}; 01 make, 11 break
//   held[NUM_KEYS]            key currently down
//   press_pulse[NUM_KEYS]     one cycle on press
//   release_pulse[NUM_KEYS]   one cycle on release
//   long_hold[NUM_KEYS]       held for >= HOLD_CYCLES edges
//   repeat_pulse[NUM_KEYS]    typematic pulses
//   any_held                  OR of held
//   combo                     every COMBO_MASK key held (one cycle behind held)
//   combo_pulse               one cycle on rising combo
// -----------------------------------------------------------------------------
module ps2_key_tracker
    import ps2_key_pkg::*;
#(
    parameter int                      NUM_KEYS      = 5,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES     = DEFAULT_KEY_CODES,
    parameter int                      HOLD_CYCLES   = 25_000_000,
    parameter int                      REPEAT_CYCLES = 5_000_000,
    parameter logic [NUM_KEYS-1:0]     COMBO_MASK    = 5'b10001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          Data,
    output logic [NUM_KEYS-1:0] held,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_hold,
    output logic [NUM_KEYS-1:0] repeat_pulse,
    output logic                any_held,
    output logic                combo,
    output logic                combo_pulse
);

    if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_num_keys
        $error("ps2_key_tracker: NUM_KEYS must be 1..16");
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        ps2_key_channel #(
            .KEY_CODE      (KEY_CODES[gi*8 +: 8]),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_channel (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_data      (Data),
            .o_held      (held[gi]),
            .o_press     (press_pulse[gi]),
            .o_release   (release_pulse[gi]),
            .o_long_hold (long_hold[gi]),
            .o_repeat    (repeat_pulse[gi])
        );
    end

    logic r_combo;
    logic r_combo_pulse;
    logic w_combo_nxt;

    // Combo condition; an all-zero mask never fires.
    always_comb begin
        w_combo_nxt = 1'b0;
        if (COMBO_MASK != '0) begin
            w_combo_nxt = ((held & COMBO_MASK) == COMBO_MASK);
        end else begin
            w_combo_nxt = 1'b0;
        end
    end

    // Combo level and its rising-edge pulse, one cycle behind held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_combo       <= 1'b0;
            r_combo_pulse <= 1'b0;
        end else begin
            r_combo       <= w_combo_nxt;
            r_combo_pulse <= w_combo_nxt & ~r_combo;
        end
    end

    assign any_held    = |held;
    assign combo       = r_combo;
    assign combo_pulse = r_combo_pulse;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_tracker
// Directed scenarios followed by randomized Data words, every cycle compared
// against a key-age reference model.
// -----------------------------------------------------------------------------
module tb_ps2_key_tracker;

    localparam int          NK    = 5;
    localparam int          HOLD  = 4;
    localparam int          RPT   = 3;
    localparam logic [39:0] CODES = {8'h29, 8'h72, 8'h75, 8'h74, 8'h6B};
    localparam logic [4:0]  MASK  = 5'b10001;
`ifdef PS2_KEY_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    Data;
    logic [NK-1:0] held, press_pulse, release_pulse, long_hold, repeat_pulse;
    logic          any_held, combo, combo_pulse;

    ps2_key_tracker #(
        .NUM_KEYS      (NK),
        .KEY_CODES     (CODES),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (RPT),
        .COMBO_MASK    (MASK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Data          (Data),
        .held          (held),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_hold     (long_hold),
        .repeat_pulse  (repeat_pulse),
        .any_held      (any_held),
        .combo         (combo),
        .combo_pulse   (combo_pulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [NK-1:0] m_held;
    int            m_age [NK];
    logic [NK-1:0] e_press, e_rel, e_long, e_rpt;
    logic          e_combo, e_combo_pulse;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] code_of(input int k);
        logic [39:0] c;
        c = CODES;
        return c[k*8 +: 8];
    endfunction

    task automatic model_reset();
        m_held = '0; e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
        e_combo = 1'b0; e_combo_pulse = 1'b0;
        for (int k = 0; k < NK; k++) m_age[k] = 0;
    endtask

    // One clock edge of the behavioural model, driven by word d.
    task automatic model_step(input logic [9:0] d);
        logic [NK-1:0] nh;
        logic cond, match, mk, bk;
        cond          = (MASK != 5'd0) && ((m_held & MASK) == MASK);
        e_combo_pulse = cond && !e_combo;
        e_combo       = cond;
        for (int k = 0; k < NK; k++) begin
            match      = d[8] && (d[7:0] == code_of(k));
            mk         = match && !d[9];
            bk         = match && d[9];
            e_press[k] = mk && !m_held[k];
            e_rel[k]   = bk && m_held[k];
            nh[k]      = mk ? 1'b1 : (bk ? 1'b0 : m_held[k]);
            if (nh[k] && m_held[k]) m_age[k] = m_age[k] + 1;
            else                    m_age[k] = 0;
            e_long[k]  = nh[k] && (m_age[k] >= HOLD);
            e_rpt[k]   = RPT_ON && e_long[k] && (((m_age[k] - HOLD) % RPT) == 0);
        end
        m_held = nh;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".held"},    32'(held),          32'(m_held));
        check_val({tag, ".press"},   32'(press_pulse),   32'(e_press));
        check_val({tag, ".release"}, 32'(release_pulse), 32'(e_rel));
        check_val({tag, ".long"},    32'(long_hold),     32'(e_long));
        check_val({tag, ".repeat"},  32'(repeat_pulse),  32'(e_rpt));
        check_val({tag, ".any"},     32'(any_held),      32'(|m_held));
        check_val({tag, ".combo"},   32'(combo),         32'(e_combo));
        check_val({tag, ".cpulse"},  32'(combo_pulse),   32'(e_combo_pulse));
    endtask

    task automatic cycle(input logic [9:0] d, input string tag);
        Data = d;
        @(posedge clk);
        model_step(d);
        #1;
        check_outputs(tag);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        check_val({tag, ".norel"}, 32'(release_pulse), 32'd0);
        @(posedge clk);
        #1;
        check_outputs({tag, ".held_rst"});
        rst = 1'b0;
    endtask

    localparam logic [9:0] IDLE = 10'h000;

    function automatic logic [9:0] mk_word(input logic [1:0] tag, input logic [7:0] code);
        return {tag, code};
    endfunction

    int          presses, held_edge, long_edge;
    logic [31:0] rpt_mask;
    logic [9:0]  w;

    initial begin
        rst  = 1'b1;
        Data = IDLE;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // left make / break
        cycle(mk_word(2'b01, 8'h6B), "left_mk");
        check_val("left_held",  32'(held[0]),        32'd1);
        check_val("left_press", 32'(press_pulse[0]), 32'd1);
        cycle(IDLE, "left_idle");
        check_val("left_press_gone", 32'(press_pulse[0]), 32'd0);
        cycle(IDLE, "left_idle2");
        cycle(mk_word(2'b11, 8'h6B), "left_brk");
        check_val("left_rel",  32'(release_pulse[0]), 32'd1);
        check_val("left_held0", 32'(held[0]),         32'd0);
        cycle(IDLE, "left_after");

        // static make held on Data for 10 cycles
        presses = 0; held_edge = -1; long_edge = -1;
        for (int c = 0; c < 10; c++) begin
            cycle(mk_word(2'b01, 8'h74), "static");
            if (press_pulse[1]) presses++;
            if (held[1] && held_edge < 0) held_edge = c;
            if (long_hold[1] && long_edge < 0) long_edge = c;
        end
        check_val("static_presses", 32'(presses), 32'd1);
        check_val("static_long_lag", 32'(long_edge - held_edge), 32'(HOLD));
        cycle(mk_word(2'b11, 8'h74), "static_brk");

        // up held for 12 edges; record which hold edges carry a repeat pulse
        rpt_mask = '0;
        cycle(mk_word(2'b01, 8'h75), "up_mk");
        for (int c = 1; c < 12; c++) begin
            cycle(IDLE, "up_hold");
            if (repeat_pulse[2]) rpt_mask[c] = 1'b1;
        end
        check_val("up_rpt_edges", rpt_mask,
                  RPT_ON ? 32'h0000_0490 : 32'h0000_0000);
        cycle(mk_word(2'b11, 8'h75), "up_brk");
        check_val("up_rel_norpt", 32'(repeat_pulse[2]), 32'd0);
        check_val("up_rel_nolong", 32'(long_hold[2]),   32'd0);

        // combo: space then left, drop space, re-press space
        cycle(mk_word(2'b01, 8'h29), "cmb_space");
        cycle(mk_word(2'b01, 8'h6B), "cmb_left");
        check_val("cmb_not_yet", 32'(combo), 32'd0);
        cycle(IDLE, "cmb_idle");
        check_val("cmb_pulse", 32'(combo_pulse), 32'd1);
        cycle(IDLE, "cmb_idle2");
        check_val("cmb_pulse_once", 32'(combo_pulse), 32'd0);
        cycle(mk_word(2'b11, 8'h29), "cmb_brk");
        cycle(IDLE, "cmb_drop");
        check_val("cmb_dropped", 32'(combo), 32'd0);
        cycle(mk_word(2'b01, 8'h29), "cmb_re");
        cycle(IDLE, "cmb_re_idle");
        check_val("cmb_repulse", 32'(combo_pulse), 32'd1);

        // filtering
        cycle(mk_word(2'b00, 8'h6B), "flt_novld");
        cycle(mk_word(2'b01, 8'h1C), "flt_unknown");
        cycle(mk_word(2'b11, 8'h72), "flt_brk_unheld");
        check_val("flt_no_rel", 32'(release_pulse), 32'd0);
        cycle(mk_word(2'b11, 8'h6B), "clr_left");
        cycle(mk_word(2'b11, 8'h29), "clr_space");

        // reset mid-hold of left and down
        cycle(mk_word(2'b01, 8'h6B), "rst_left");
        cycle(mk_word(2'b01, 8'h72), "rst_down");
        cycle(IDLE, "rst_idle");
        pulse_reset("midhold");
        cycle(mk_word(2'b01, 8'h6B), "post_rst_mk");
        check_val("post_rst_press", 32'(press_pulse[0]), 32'd1);

        // randomized words
        w = IDLE;
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 25) begin
                // keep the previous word on Data
            end else if (r < 40) begin
                w = {1'b0 ^ $urandom_range(0, 1) == 1, 1'b0, 8'($urandom_range(0, 255))};
            end else if (r < 45) begin
                w = {1'($urandom_range(0, 1)), 1'b1, 8'h1C};
            end else begin
                w = {1'($urandom_range(0, 2) == 0), 1'b1, code_of(int'($urandom_range(0, NK - 1)))};
            end
            if ($urandom_range(0, 499) == 0) pulse_reset("rnd_rst");
            cycle(w, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 key-state tracker between the PS/2 receiver and the game and control logic. It watches the decoded 10-bit `Data` word and tracks up to `NUM_KEYS` configurable scancodes. For each key it provides a held level, one-cycle press and release pulses, and a long-hold flag. It also flags a configurable key combination and, optionally, generates typematic repeat pulses.

## Interface
- `NUM_KEYS`, default 5: number of tracked keys, 1..16.
- `KEY_CODES`, default `{8'h29,8'h72,8'h75,8'h74,8'h6B}`: packed `NUM_KEYS*8` scancodes; index 0 in the LSBs (0 left, 1 right, 2 up, 3 down, 4 space).
- `HOLD_CYCLES`, default 25_000_000: cycles a key must be held before `long_hold`; must be ≥1.
- `REPEAT_CYCLES`, default 5_000_000: repeat period once `long_hold` is set; must be ≥1.
- `COMBO_MASK`, default `5'b10001`: keys that form the combo; all-zero disables the combo.
- `clk  in  1`: system clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `Data  in  10`: `{brk, vld, scancode[7:0]}`; `2'b01` = make, `2'b11` = break, `vld=0` = no event. May hold one value for many cycles.
- `held  out  NUM_KEYS`: key currently down.
- `press_pulse  out  NUM_KEYS`: one cycle on a 0→1 transition of `held`.
- `release_pulse  out  NUM_KEYS`: one cycle on a 1→0 transition of `held`.
- `long_hold  out  NUM_KEYS`: key held for ≥ `HOLD_CYCLES`.
- `repeat_pulse  out  NUM_KEYS`: typematic pulses; constant 0 without the macro.
- `any_held  out  1`: OR of `held`.
- `combo  out  1`: every `COMBO_MASK` key is held.
- `combo_pulse  out  1`: one cycle on a rising edge of `combo`.

## Operation
- **Decode.** Compare `Data[7:0]` against each `KEY_CODES` entry while `vld=1`.
  - Make sets `held[i]`; break clears it.
  - If several entries share a code, all of them update.
  - `vld=0` words are ignored.
- **Idempotent input.** A repeated or static `Data` value has no further effect. A make arriving while the key is already held gives no `press_pulse`. A break arriving while the key is already released gives no `release_pulse`.
- **Pulses.**
  - `press_pulse[i]` = make match & ~`held[i]`.
  - `release_pulse[i]` = break match & `held[i]`.
  - Both are registered on the same edge that updates `held`.
- **Hold counter.**
  - One saturating counter per key, width `$clog2(HOLD_CYCLES+1)`.
  - Cleared when the key is not held; increments each cycle the key is held.
  - `long_hold[i]` sets when the counter reaches `HOLD_CYCLES` and clears on the edge `held[i]` falls.
- **Combo.**
  - `combo` = (`COMBO_MASK` != 0) & ((`held` & `COMBO_MASK`) == `COMBO_MASK`), registered.
  - `combo_pulse` fires once per rising edge of `combo`.
  - Releasing any member drops `combo`; pressing it again re-arms `combo_pulse`.
- **Reset.** All outputs and counters go to 0. Reset mid-hold produces no `release_pulse`.

## Timing
- Latency is one cycle: a make on `Data` before edge k gives `held`=1 and `press_pulse`=1 after edge k. `press_pulse` is 0 after edge k+1.
- `long_hold` rises exactly `HOLD_CYCLES` edges after the edge where `held` rose.
- `combo` and `combo_pulse` lag `held` by one cycle.
- `repeat_pulse[i]` (macro on):
  - first pulse on the same edge `long_hold` rises;
  - then one pulse every `REPEAT_CYCLES` edges while the key stays held;
  - stops on the release edge, with no pulse on that edge.

## Configuration
- **`PS2_KEY_REPEAT_EN` defined:** a per-key repeat counter of width `$clog2(REPEAT_CYCLES+1)` drives `repeat_pulse` as described under Timing.
- **Macro undefined:** no repeat counter is built and `repeat_pulse` is tied to 0. The port list is unchanged.

## Structure
- Package `ps2_key_pkg` holds:
  - scancode constants `KEY_LEFT` (6B), `KEY_RIGHT` (74), `KEY_UP` (75), `KEY_DOWN` (72), `KEY_SPACE` (29);
  - make and break tag constants `2'b01` and `2'b11`;
  - the default `KEY_CODES` vector.
- Sub-module `ps2_key_channel` holds one key's logic: held register, pulses, hold counter and the optional repeat counter. It is instantiated `NUM_KEYS` times with a generate loop.
- The top level keeps only `any_held` and the combo logic.

## Test plan
All scenarios use `HOLD_CYCLES=4`, `REPEAT_CYCLES=3` and default codes.
- **Left make/break.** `{01,6B}` for 1 cycle, then idle, then `{11,6B}`:
  - `held[0]`=1 after the edge;
  - `press_pulse[0]` high for exactly 1 cycle;
  - on break, `release_pulse[0]` high for 1 cycle and `held[0]`=0.
- **Static input.** `{01,74}` held on `Data` for 10 cycles → one `press_pulse[1]` only. `long_hold[1]` rises 4 edges after `held[1]`.
- **Repeat (macro on).** Hold up for 12 cycles → `repeat_pulse[2]` at hold edges 4, 7 and 10. Release → no pulse; `long_hold[2]`=0.
- **Combo.** Make space, then left → `combo`=1 and `combo_pulse` for 1 cycle, one cycle after `held[0]` rises. Break space → `combo`=0. Make space again → `combo_pulse` fires again.
- **Filtering.**
  - `{00,6B}` and `{01,1C}` → no output change.
  - A break for an unheld key → no `release_pulse`.
- **Reset.** Assert `rst` mid-hold of left and down → all outputs 0 immediately (asynchronous reset), with no `release_pulse`. After deassert, a make works normally.
